// File: rtl/swd_pkg.sv
// Shared types and constants for the SWD transfer engine.
package swd_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StPad,
    StReq,
    StTrn1,
    StAck,
    StTrn2,
    StWdata,
    StWpar,
    StRdata,
    StRpar,
    StTrn3,
    StDone
  } swd_state_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_WAIT_EXH = 2'd1,
    ST_FAULT    = 2'd2,
    ST_PROTO    = 2'd3
  } swd_status_e;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

endpackage

// File: rtl/swd_shift_unit.sv
// LSB-first data shifter with running XOR parity, shared by the write and read data phases.
module swd_shift_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              sck,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift,
  input  logic              rx,
  input  logic              shift_in,
  output logic [DATA_W-1:0] data,
  output logic              parity,
  output logic              bit_next,
  output logic              parity_next
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;

  always_comb begin
    data_d = data_q;
    par_d  = par_q;
    if (load) begin
      data_d = load_data;
      par_d  = 1'b0;
    end else if (shift) begin
      // Parity covers the bits that cross the line in either direction.
      par_d  = par_q ^ (rx ? shift_in : data_q[0]);
      data_d = {shift_in, data_q[DATA_W-1:1]};
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
    end
  end

  assign data        = data_q;
  assign parity      = par_q;
  assign bit_next    = data_d[0];
  assign parity_next = par_d;

endmodule

// File: rtl/swd_xfer_engine.sv
// Runs one SWD read or write transaction per accepted request, retrying on WAIT ACKs.
module swd_xfer_engine
  import swd_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned TRN_CYCLES = 1,
  parameter int unsigned PAD_BITS   = 2,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic              sck,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [7:0]        req_byte,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [1:0]        rsp_status,
  output logic [2:0]        rsp_ack,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_perr,
  output logic              swdio_out,
  output logic              swdio_oe,
  input  logic              swdio_in,
  output logic              swclk_en
);

  localparam int unsigned CntW   = $clog2((DATA_W > 8 ? DATA_W : 8) + 1);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CntW-1:0] PadLast  = CntW'(PAD_BITS - 1);
  localparam logic [CntW-1:0] TrnLast  = CntW'(TRN_CYCLES - 1);
  localparam logic [CntW-1:0] DataLast = CntW'(DATA_W - 1);
  localparam logic [CntW-1:0] ReqLast  = CntW'(7);
  localparam logic [CntW-1:0] AckLast  = CntW'(2);
  localparam swd_state_e FirstSt = (PAD_BITS == 0) ? StReq : StPad;

  swd_state_e        state_q, state_d;
  swd_status_e       status_q, status_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic              redo_q, redo_d;
  logic              start_q, start_d;
  logic [2:0]        ack_q, ack_d, ack_now;
  logic              perr_q, perr_d;
  logic [7:0]        req_q;
  logic              accept, oe_d, out_d;
  logic [DATA_W-1:0] sh_data;
  logic              sh_parity, sh_bit_next, sh_par_next;

  assign accept = req_valid && req_ready;

  swd_shift_unit #(
    .DATA_W(DATA_W)
  ) u_shift (
    .sck        (sck),
    .rst_n      (rst_n),
    .load       (accept),
    .load_data  (req_wdata),
    .shift      ((state_q == StWdata) || (state_q == StRdata)),
    .rx         (req_q[2]),
    .shift_in   (swdio_in),
    .data       (sh_data),
    .parity     (sh_parity),
    .bit_next   (sh_bit_next),
    .parity_next(sh_par_next)
  );

  // state_q names the bit currently on the line; the edge ending it samples swdio_in.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CntW'(1);
    retry_d  = retry_q;
    redo_d   = redo_q;
    status_d = status_q;
    ack_d    = ack_q;
    perr_d   = perr_q;
    start_d  = accept;
    ack_now  = {swdio_in, ack_q[2:1]};
    if (accept) begin
      retry_d = '0;
      redo_d  = 1'b0;
      perr_d  = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start_q) state_d = FirstSt;
      end
      StPad: if (cnt_q == PadLast) begin state_d = StReq; cnt_d = '0; end
      StReq: if (cnt_q == ReqLast) begin state_d = StTrn1; cnt_d = '0; end
      StTrn1: if (cnt_q == TrnLast) begin state_d = StAck; cnt_d = '0; end
      StAck: begin
        ack_d = ack_now;
        if (cnt_q == AckLast) begin
          cnt_d   = '0;
          state_d = StTrn3;
          redo_d  = 1'b0;
          if (ack_now == ACK_OK) begin
            status_d = ST_OK;
            state_d  = req_q[2] ? StRdata : StTrn2;
          end else if (ack_now == ACK_WAIT && retry_q < RetryW'(MAX_RETRY)) begin
            retry_d = retry_q + RetryW'(1);
            redo_d  = 1'b1;
          end else if (ack_now == ACK_WAIT) begin
            status_d = ST_WAIT_EXH;
          end else if (ack_now == ACK_FAULT) begin
            status_d = ST_FAULT;
          end else begin
            status_d = ST_PROTO;
          end
        end
      end
      StTrn2: if (cnt_q == TrnLast) begin state_d = StWdata; cnt_d = '0; end
      StWdata: if (cnt_q == DataLast) begin state_d = StWpar; cnt_d = '0; end
      StWpar: begin state_d = StDone; cnt_d = '0; end
      StRdata: if (cnt_q == DataLast) begin state_d = StRpar; cnt_d = '0; end
      StRpar: begin
        perr_d  = swdio_in ^ sh_parity;
        state_d = StTrn3;
        cnt_d   = '0;
      end
      StTrn3: if (cnt_q == TrnLast) begin
        state_d = redo_q ? FirstSt : StDone;
        cnt_d   = '0;
      end
      StDone: begin state_d = StIdle; cnt_d = '0; end
      default: begin state_d = StIdle; cnt_d = '0; end
    endcase

    oe_d  = 1'b0;
    out_d = 1'b0;
    unique case (state_d)
      StPad: oe_d = 1'b1;
      StReq: begin oe_d = 1'b1; out_d = req_q[cnt_d[2:0]]; end
      StWdata: begin oe_d = 1'b1; out_d = sh_bit_next; end
      StWpar: begin oe_d = 1'b1; out_d = sh_par_next; end
      default: ;
    endcase
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      status_q   <= ST_OK;
      cnt_q      <= '0;
      retry_q    <= '0;
      redo_q     <= 1'b0;
      start_q    <= 1'b0;
      ack_q      <= '0;
      perr_q     <= 1'b0;
      req_q      <= '0;
      req_ready  <= 1'b1;
      swdio_oe   <= 1'b0;
      swdio_out  <= 1'b0;
      swclk_en   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= ST_OK;
      rsp_ack    <= '0;
      rsp_rdata  <= '0;
      rsp_perr   <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      redo_q    <= redo_d;
      start_q   <= start_d;
      ack_q     <= ack_d;
      perr_q    <= perr_d;
      if (accept) req_q <= req_byte;
      req_ready <= (state_d == StIdle) && !start_d;
      swdio_oe  <= oe_d;
      swdio_out <= out_d;
      swclk_en  <= !(state_d inside {StIdle, StDone});
      rsp_valid <= (state_d == StDone);
      if (state_d == StDone) begin
        rsp_status <= status_d;
        rsp_ack    <= ack_d;
        rsp_perr   <= perr_d;
        rsp_rdata  <= (req_q[2] && status_d == ST_OK) ? sh_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_swd_xfer_engine.sv
// Scoreboard bench: stimulus queues expected line bits and responses, monitors pop and compare.
module tb_swd_xfer_engine;

  localparam int DW = 32;
  localparam int TRN = 1;
  localparam int PAD = 2;
  localparam int MAXR = 3;

  typedef struct {
    logic oe;
    logic out;
    logic chk_out;
    logic din;
  } bit_t;

  typedef struct {
    logic [1:0]  status;
    logic [2:0]  ack;
    logic [31:0] rdata;
    logic        perr;
    int          cyc;
  } exp_t;

  logic sck = 1'b0;
  always #5 sck = ~sck;

  logic        rst_n, req_valid, req_ready, rsp_valid, rsp_perr;
  logic        swdio_out, swdio_oe, swdio_in, swclk_en;
  logic [7:0]  req_byte;
  logic [31:0] req_wdata, rsp_rdata;
  logic [1:0]  rsp_status;
  logic [2:0]  rsp_ack;

  logic       r2_valid, r2_ready, r2_rsp_valid, r2_perr, r2_out, r2_oe, r2_in, r2_en;
  logic [7:0] r2_byte, r2_wdata, r2_rdata;
  logic [1:0] r2_status;
  logic [2:0] r2_ack;

  swd_xfer_engine #(
    .DATA_W(DW), .TRN_CYCLES(TRN), .PAD_BITS(PAD), .MAX_RETRY(MAXR)
  ) dut (
    .sck(sck), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_byte(req_byte), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_status(rsp_status), .rsp_ack(rsp_ack), .rsp_rdata(rsp_rdata), .rsp_perr(rsp_perr),
    .swdio_out(swdio_out), .swdio_oe(swdio_oe), .swdio_in(swdio_in), .swclk_en(swclk_en)
  );

  swd_xfer_engine #(
    .DATA_W(8), .TRN_CYCLES(2), .PAD_BITS(2), .MAX_RETRY(3)
  ) dut_small (
    .sck(sck), .rst_n(rst_n), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_byte(r2_byte), .req_wdata(r2_wdata), .rsp_valid(r2_rsp_valid),
    .rsp_status(r2_status), .rsp_ack(r2_ack), .rsp_rdata(r2_rdata), .rsp_perr(r2_perr),
    .swdio_out(r2_out), .swdio_oe(r2_oe), .swdio_in(r2_in), .swclk_en(r2_en)
  );

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit_t line_q[$];
  exp_t exp_q[$];
  bit_t frame[$];
  bit_t mon_b;
  exp_t mon_e;

  always @(posedge sck) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Line monitor: one expected entry per bit cycle while the clock gate is open.
  always @(negedge sck) begin
    if (rst_n && swclk_en) begin
      if (line_q.size() == 0) begin
        chk("line_extra_bit", 1, 0);
      end else begin
        mon_b = line_q.pop_front();
        chk("line_oe", swdio_oe, mon_b.oe);
        if (mon_b.chk_out) chk("line_out", swdio_out, mon_b.out);
      end
    end
  end

  always @(negedge sck) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_status", rsp_status, mon_e.status);
        chk("rsp_ack", rsp_ack, mon_e.ack);
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_perr", rsp_perr, mon_e.perr);
        chk("rsp_cycle", cyc, mon_e.cyc);
      end
    end
  end

  function automatic void push_bit(logic oe, logic out, logic c, logic din);
    bit_t b;
    b.oe = oe; b.out = out; b.chk_out = c; b.din = din;
    frame.push_back(b);
  endfunction

  // Target-side frame: what the host must drive and what the target returns, per bit.
  function automatic void build(logic [7:0] rb, logic [31:0] wd, logic [31:0] rd, logic rpar,
                                logic [11:0] acks);
    logic [2:0] a3;
    frame.delete();
    for (int a = 0; a <= MAXR; a++) begin
      a3 = acks[3*a +: 3];
      for (int i = 0; i < PAD; i++) push_bit(1'b1, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 8; i++) push_bit(1'b1, rb[i], 1'b1, 1'b0);
      for (int i = 0; i < TRN; i++) push_bit(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) push_bit(1'b0, 1'b0, 1'b0, a3[i]);
      if (a3 == 3'b001) begin
        if (rb[2]) begin
          for (int i = 0; i < DW; i++) push_bit(1'b0, 1'b0, 1'b0, rd[i]);
          push_bit(1'b0, 1'b0, 1'b0, rpar);
          for (int i = 0; i < TRN; i++) push_bit(1'b0, 1'b0, 1'b0, 1'b1);
        end else begin
          for (int i = 0; i < TRN; i++) push_bit(1'b0, 1'b0, 1'b0, 1'b1);
          for (int i = 0; i < DW; i++) push_bit(1'b1, wd[i], 1'b1, 1'b0);
          push_bit(1'b1, ^wd, 1'b1, 1'b0);
        end
        break;
      end
      for (int i = 0; i < TRN; i++) push_bit(1'b0, 1'b0, 1'b0, 1'b1);
      if (a3 != 3'b010) break;
    end
  endfunction

  task automatic accept(input logic [7:0] rb, input logic [31:0] wd, input int nbits,
                        output int ce, output bit ok);
    int n = 0;
    @(negedge sck);
    req_valid = 1'b1; req_byte = rb; req_wdata = wd;
    while (!req_ready && n < 200) begin @(negedge sck); n++; end
    ok = req_ready;
    if (!ok) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0;
      ce = cyc;
      return;
    end
    for (int i = 0; i < nbits; i++) line_q.push_back(frame[i]);
    @(posedge sck);
    #1 req_valid = 1'b0;
    ce = cyc;
  endtask

  task automatic xfer(input logic [7:0] rb, input logic [31:0] wd, input logic [31:0] rd,
                      input logic rpar, input logic [11:0] acks, input logic [1:0] st,
                      input logic [2:0] ack, input logic [31:0] rdata, input logic perr,
                      input int len, input bit poke);
    int ce;
    bit ok;
    exp_t e;
    build(rb, wd, rd, rpar, acks);
    accept(rb, wd, frame.size(), ce, ok);
    if (!ok) return;
    e.status = st; e.ack = ack; e.rdata = rdata; e.perr = perr; e.cyc = ce + len + 1;
    exp_q.push_back(e);
    @(negedge sck);
    foreach (frame[i]) begin
      @(negedge sck);
      swdio_in = frame[i].din;
      // A request raised mid-frame must be ignored.
      if (poke && i >= 3 && i < 6) begin
        req_valid = 1'b1; req_byte = 8'hFF;
      end else begin
        req_valid = 1'b0;
      end
    end
    @(negedge sck);
    swdio_in = 1'b0;
    @(negedge sck);
  endtask

  task automatic reset_mid();
    int ce;
    bit ok;
    build(8'hA1, 32'hCAFEBABE, 32'h0, 1'b0, 12'h001);
    accept(8'hA1, 32'hCAFEBABE, 20, ce, ok);
    if (!ok) return;
    @(negedge sck);
    for (int i = 0; i < 20; i++) begin
      @(negedge sck);
      swdio_in = frame[i].din;
    end
    @(posedge sck);
    #1 chk("pre_rst_oe", swdio_oe, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oe", swdio_oe, 0);
    chk("rst_mid_clk_en", swclk_en, 0);
    chk("rst_mid_ready", req_ready, 1);
    chk("rst_mid_valid", rsp_valid, 0);
    @(negedge sck);
    @(negedge sck);
    rst_n = 1'b1;
    @(negedge sck);
  endtask

  task automatic small_frame();
    int ce, en_cnt, got;
    logic [7:0] wd2;
    wd2 = 8'h5A;
    en_cnt = 0;
    got = 0;
    @(negedge sck);
    chk("r2_ready", r2_ready, 1);
    r2_valid = 1'b1; r2_byte = 8'hA1; r2_wdata = wd2;
    @(posedge sck);
    #1 r2_valid = 1'b0;
    ce = cyc;
    @(negedge sck);
    for (int k = 0; k < 32; k++) begin
      @(negedge sck);
      r2_in = (k == 12);
      if (r2_en) en_cnt++;
      if (k >= 10 && k <= 16) chk("r2_trn_ack_oe", r2_oe, 0);
      if (k >= 17 && k <= 24) chk("r2_wdata_bit", r2_out, wd2[k-17]);
      if (k == 25) begin
        chk("r2_wpar_oe", r2_oe, 1);
        chk("r2_wpar", r2_out, 0);
      end
      if (r2_rsp_valid) begin
        got = cyc - ce;
        chk("r2_status", r2_status, 0);
        chk("r2_ack", r2_ack, 3'b001);
      end
    end
    chk("r2_frame_bits", en_cnt, 26);
    chk("r2_rsp_cycle", got, 27);
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0; req_byte = '0; req_wdata = '0; swdio_in = 1'b0;
    r2_valid = 1'b0; r2_byte = '0; r2_wdata = '0; r2_in = 1'b0;
    #1 rst_n = 1'b0;
    #11;
    chk("reset_ready", req_ready, 1);
    chk("reset_oe", swdio_oe, 0);
    chk("reset_out", swdio_out, 0);
    chk("reset_clk_en", swclk_en, 0);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_status", rsp_status, 0);
    chk("reset_ack", rsp_ack, 0);
    chk("reset_rdata", rsp_rdata, 0);
    chk("reset_perr", rsp_perr, 0);
    @(negedge sck);
    rst_n = 1'b1;

    xfer(8'hA1, 32'hCAFEBABE, 32'h0, 1'b0, 12'h001, 2'd0, 3'b001, 32'h0, 1'b0, 48, 1'b0);
    xfer(8'hA5, 32'h0, 32'h12345678, 1'b1, 12'h001, 2'd0, 3'b001, 32'h12345678, 1'b0, 48,
         1'b0);
    xfer(8'hA5, 32'h0, 32'h12345678, 1'b0, 12'h001, 2'd0, 3'b001, 32'h12345678, 1'b1, 48,
         1'b0);
    xfer(8'hA1, 32'h80000001, 32'h0, 1'b0, 12'h052, 2'd0, 3'b001, 32'h0, 1'b0, 78, 1'b1);
    xfer(8'hA5, 32'hDEADBEEF, 32'h0, 1'b0, 12'h492, 2'd1, 3'b010, 32'h0, 1'b0, 60, 1'b0);
    xfer(8'hA1, 32'h0000FFFF, 32'h0, 1'b0, 12'h004, 2'd2, 3'b100, 32'h0, 1'b0, 15, 1'b0);
    xfer(8'hA5, 32'h0, 32'hFFFFFFFF, 1'b0, 12'h007, 2'd3, 3'b111, 32'h0, 1'b0, 15, 1'b0);
    reset_mid();
    xfer(8'hB1, 32'h0F0F0001, 32'h0, 1'b0, 12'h001, 2'd0, 3'b001, 32'h0, 1'b0, 48, 1'b0);
    small_frame();

    repeat (5) @(negedge sck);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("line_drained", line_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
